// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the BCD-to-binary converter.
// The master side issues digit-entry requests; the slave side returns binary results.
interface bcd_to_bin_if #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                in_valid;
    logic                in_ready;
    logic [BIN_W-1:0]    data;
    logic                out_valid;
    logic                err;

    modport master (
        output bcd_in,
        output in_valid,
        input  in_ready,
        input  data,
        input  out_valid,
        input  err
    );

    modport slave (
        input  bcd_in,
        input  in_valid,
        output in_ready,
        output data,
        output out_valid,
        output err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential 6-digit packed-BCD to 20-bit binary converter (reverse double-dabble).
// Define BCD_DIGIT_CHECK_EN to flag digits above 9 via err and force the result to zero.
module bcd_to_bin #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20,
    parameter int CNT_W  = 5
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    bcd_to_bin_if.slave  bus
);

    localparam int WORK_W = 4*DIGITS + BIN_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]        r_state;
    logic [WORK_W-1:0] r_work;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIN_W-1:0]  r_data;
    logic              r_out_valid;
    logic              r_err;
    logic              r_err_q;

    logic [WORK_W-1:0] w_shift;
    logic [WORK_W-1:0] w_next;
    logic              w_digit_bad;
    logic              w_last;

    // One iteration: shift the whole work register right, then correct any BCD nibble that went >= 8.
    always_comb begin
        w_shift = r_work >> 1;
        w_next  = w_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_shift[BIN_W + 4*i +: 4] >= 4'd8) begin
                w_next[BIN_W + 4*i +: 4] = w_shift[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_comb begin
        w_digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                w_digit_bad = 1'b1;
            end
        end
    end
`else
    assign w_digit_bad = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_work  <= {bus.bcd_in, {BIN_W{1'b0}}};
                        r_cnt   <= '0;
                        r_err_q <= w_digit_bad;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // A flagged request still runs all iterations but reports a zero result.
                        r_data      <= r_err_q ? '0 : w_next[BIN_W-1:0];
                        r_err       <= r_err_q;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.data      = r_data;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases plus random valid BCD against a decimal model.
// Expected err/data for bad digits follow BCD_DIGIT_CHECK_EN when it is defined for the build.
module tb_bcd_to_bin;

    logic sys_clk;
    logic sys_rst_n;
    int   passCount  = 0;
    int   failCount  = 0;
    int   totalCount = 0;

    bcd_to_bin_if #(.DIGITS(6), .BIN_W(20)) bus ();

    bcd_to_bin #(.DIGITS(6), .BIN_W(20), .CNT_W(5)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Decimal value of the packed digits, most significant digit first.
    function automatic logic [19:0] refValue(input logic [23:0] b);
        int v;
        v = 0;
        for (int i = 5; i >= 0; i--) begin
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return 20'(v);
    endfunction

    function automatic bit hasBadDigit(input logic [23:0] b);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [23:0] randomBcd();
        logic [23:0] b;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] bcd, input logic valid);
        bus.bcd_in   = bcd;
        bus.in_valid = valid;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Count edges until out_valid is seen; 0 means the bound expired.
    task automatic awaitResult(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic countStrobes(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
    endtask

    // Single pulsed request: checks busy, latency, result, error and strobe width.
    task automatic runOne(input string tag, input logic [23:0] bcd, input bit checkData);
        int lat;
        checkOutput({tag, " ready_before"}, 32'(bus.in_ready), 32'd1);
        applyStimulus(bcd, 1'b1);
        tick();
        applyStimulus(bcd, 1'b0);
        checkOutput({tag, " busy"}, 32'(bus.in_ready), 32'd0);
        awaitResult(lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'd20);
`ifdef BCD_DIGIT_CHECK_EN
        checkOutput({tag, " err"}, 32'(bus.err), 32'(hasBadDigit(bcd)));
        if (checkData)
            checkOutput({tag, " data"}, 32'(bus.data), hasBadDigit(bcd) ? 32'd0 : 32'(refValue(bcd)));
`else
        checkOutput({tag, " err"}, 32'(bus.err), 32'd0);
        if (checkData && !hasBadDigit(bcd))
            checkOutput({tag, " data"}, 32'(bus.data), 32'(refValue(bcd)));
`endif
        checkOutput({tag, " ready_with_result"}, 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput({tag, " strobe_width"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [23:0] held;

        applyStimulus(24'h0, 1'b0);
        sys_rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset data", 32'(bus.data), 32'd0);
        checkOutput("reset err", 32'(bus.err), 32'd0);
        sys_rst_n = 1'b1;
        tick();
        checkOutput("reset ready", 32'(bus.in_ready), 32'd1);

        runOne("zero", 24'h000000, 1'b1);
        runOne("max", 24'h999999, 1'b1);
        checkOutput("max literal", 32'(bus.data), 32'h000F423F);
        runOne("nine", 24'h000009, 1'b1);
        runOne("bad_digit", 24'h00A000, 1'b1);
        runOne("123456", 24'h123456, 1'b1);
        checkOutput("123456 literal", 32'(bus.data), 32'h0001E240);

        // Abort a conversion with reset at its tenth iteration.
        applyStimulus(24'h000555, 1'b1);
        tick();
        applyStimulus(24'h000555, 1'b0);
        for (int k = 0; k < 9; k++) tick();
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort data", 32'(bus.data), 32'd0);
        checkOutput("abort ready", 32'(bus.in_ready), 32'd1);
        countStrobes(30, seen);
        checkOutput("abort no_strobe", 32'(seen), 32'd0);
        runOne("after_abort", 24'h000042, 1'b1);
        checkOutput("after_abort literal", 32'(bus.data), 32'h0000002A);

        // A pulse while busy must be dropped.
        applyStimulus(24'h000001, 1'b1);
        tick();
        applyStimulus(24'h000001, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        applyStimulus(24'h000777, 1'b1);
        tick();
        applyStimulus(24'h000777, 1'b0);
        awaitResult(lat);
        checkOutput("drop latency", 32'(lat), 32'd16);
        checkOutput("drop data", 32'(bus.data), 32'd1);
        countStrobes(30, seen);
        checkOutput("drop single_strobe", 32'(seen), 32'd0);

        // Back-to-back with in_valid held and bcd_in changed mid-conversion.
        applyStimulus(24'h000100, 1'b1);
        tick();
        applyStimulus(24'h065535, 1'b1);
        checkOutput("b2b busy", 32'(bus.in_ready), 32'd0);
        awaitResult(lat);
        checkOutput("b2b first latency", 32'(lat), 32'd20);
        checkOutput("b2b first data", 32'(bus.data), 32'(refValue(24'h000100)));
        checkOutput("b2b first ready", 32'(bus.in_ready), 32'd1);
        tick();
        applyStimulus(24'h000000, 1'b0);
        checkOutput("b2b accepted", 32'(bus.in_ready), 32'd0);
        checkOutput("b2b strobe_width", 32'(bus.out_valid), 32'd0);
        awaitResult(lat);
        checkOutput("b2b second latency", 32'(lat), 32'd20);
        checkOutput("b2b second data", 32'(bus.data), 32'h0000FFFF);
        tick();

        for (int n = 0; n < 8; n++) begin
            held = randomBcd();
            runOne($sformatf("random%0d", n), held, 1'b1);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
